// File: rtl/fp_acc_seq.sv
// Multi-cycle floating-point adder/accumulator: pairwise add (mode 0) or run sum (mode 1), truncating, exceptions flush to zero.
// Result 4 cycles after accept (ALIGN, ADD, NORM, OUT); one beat in flight, so in_ready drops until IDLE; OUT holds under out_ready=0.
module fp_acc_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 8,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mode,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic             i_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [W-1:0]     o_out,
  output logic             o_ex,
  output logic [CNT_W-1:0] o_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp_t;

  localparam int               LZ_W    = $clog2(MAN_W + 2);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] SH_MAX  = EXP_W'(MAN_W + 1);

  state_t r_state, w_state_nxt;

  logic             r_first, r_mode, r_end;
  fp_t              r_opa, r_opb, r_acc;
  logic             r_ex;
  logic [CNT_W-1:0] r_cnt;

  logic             r_big_s, r_sub;
  logic [EXP_W-1:0] r_big_e;
  logic [MAN_W:0]   r_big_m, r_sml_m;

  logic [MAN_W+1:0] r_sum;
  logic [EXP_W-1:0] r_sum_e;
  logic             r_sum_s;

  fp_t              r_out;
  logic             r_out_ex;
  logic [CNT_W-1:0] r_out_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) w_state_nxt = S_ALIGN;
      end
      S_ALIGN: w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = r_end ? S_OUT : S_IDLE;
      S_OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Mode is sampled only on the first beat of a run.
  logic w_accept, w_mode_eff, w_run_end;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_mode_eff = r_first ? i_mode : r_mode;
  assign w_run_end  = !w_mode_eff | i_last;

  logic             w_a_big, w_inf;
  logic [MAN_W:0]   w_a_m, w_b_m, w_sml_m, w_sml_sh;
  logic [EXP_W-1:0] w_sml_e, w_diff;

  always_comb begin
    w_a_m    = (r_opa.e == '0) ? '0 : {1'b1, r_opa.m};
    w_b_m    = (r_opb.e == '0) ? '0 : {1'b1, r_opb.m};
    w_a_big  = {r_opa.e, w_a_m} >= {r_opb.e, w_b_m};
    w_sml_m  = w_a_big ? w_b_m   : w_a_m;
    w_sml_e  = w_a_big ? r_opb.e : r_opa.e;
    w_diff   = (w_a_big ? r_opa.e : r_opb.e) - w_sml_e;
    w_sml_sh = (w_diff > SH_MAX) ? '0 : (w_sml_m >> w_diff);
    w_inf    = (r_opa.e == EXP_MAX) | (r_opb.e == EXP_MAX);
  end

  logic [LZ_W-1:0]  w_lz;
  logic [MAN_W-1:0] w_frac;
  logic [EXP_W+1:0] w_exp_n;
  logic             w_zero, w_uf, w_ovf;
  fp_t              w_res;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i <= MAN_W; i++) begin
      if (r_sum[i]) w_lz = LZ_W'(MAN_W - i);
    end
  end

  // Exponent carried two bits wide so underflow shows as a set MSB.
  always_comb begin
    if (r_sum[MAN_W+1]) begin
      w_frac  = r_sum[MAN_W:1];
      w_exp_n = {2'b00, r_sum_e} + (EXP_W+2)'(1);
    end else begin
      w_frac  = MAN_W'(r_sum[MAN_W:0] << w_lz);
      w_exp_n = {2'b00, r_sum_e} - (EXP_W+2)'(w_lz);
    end
    w_zero = (r_sum == '0);
    w_uf   = w_exp_n[EXP_W+1] | (w_exp_n == '0);
    w_ovf  = !w_zero && !w_uf && (w_exp_n >= {2'b00, EXP_MAX});
    if (w_zero || w_uf || w_ovf) w_res = '0;
    else                         w_res = {r_sum_s, w_exp_n[EXP_W-1:0], w_frac};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_first   <= 1'b1;
      r_mode    <= 1'b0;
      r_end     <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_ex      <= 1'b0;
      r_cnt     <= '0;
      r_big_s   <= 1'b0;
      r_sub     <= 1'b0;
      r_big_e   <= '0;
      r_big_m   <= '0;
      r_sml_m   <= '0;
      r_sum     <= '0;
      r_sum_e   <= '0;
      r_sum_s   <= 1'b0;
      r_out     <= '0;
      r_out_ex  <= 1'b0;
      r_out_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_first <= w_run_end;
          r_mode  <= w_mode_eff;
          r_end   <= w_run_end;
          r_opa   <= i_a;
          r_opb   <= !w_mode_eff ? i_b : (r_first ? '0 : r_acc);
          if (r_first) begin
            r_ex  <= 1'b0;
            r_cnt <= CNT_W'(1);
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ALIGN: begin
          r_big_s <= w_a_big ? r_opa.s : r_opb.s;
          r_sub   <= r_opa.s ^ r_opb.s;
          r_big_e <= w_a_big ? r_opa.e : r_opb.e;
          r_big_m <= w_a_big ? w_a_m : w_b_m;
          r_sml_m <= w_sml_sh;
          if (w_inf) r_ex <= 1'b1;
        end
        S_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_big_m} - {1'b0, r_sml_m})
                           : ({1'b0, r_big_m} + {1'b0, r_sml_m});
          r_sum_e <= r_big_e;
          r_sum_s <= r_big_s;
        end
        S_NORM: begin
          if (r_end) begin
            r_out     <= (r_ex | w_ovf) ? '0 : w_res;
            r_out_ex  <= r_ex | w_ovf;
            r_out_cnt <= r_cnt;
          end else begin
            r_acc <= w_res;
            if (w_ovf) r_ex <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out = r_out;
  assign o_ex  = r_out_ex;
  assign o_cnt = r_out_cnt;

endmodule

// File: tb/tb_fp_acc_seq.sv
// Directed bench for fp_acc_seq: table of mode-0 pairs plus hand-written accumulate, backpressure and reset sequences.
module tb_fp_acc_seq;

  logic        clk = 1'b0;
  logic        rst_n, mode, in_valid, in_ready, last, out_valid, out_ready, ex;
  logic [31:0] a, b, out;
  logic [7:0]  cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_acc_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_last      (last),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out       (out),
    .o_ex        (ex),
    .o_cnt       (cnt)
  );

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_out;
    logic        exp_ex;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until the edge where in_ready accepts it.
  task automatic send(input logic m, input logic [31:0] va, input logic [31:0] vb, input logic l);
    int n = 0;
    mode = m; a = va; b = vb; last = l; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] acc_vals[4];

    vecs[0]  = '{32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0};
    vecs[1]  = '{32'h4B7FFFFF, 32'h3F800000, 32'h4B800000, 1'b0};
    vecs[2]  = '{32'h4B7FFFFF, 32'h40000000, 32'h4B800000, 1'b0};
    vecs[3]  = '{32'hBF800000, 32'h3F800000, 32'h00000000, 1'b0};
    vecs[4]  = '{32'h3F800000, 32'hC0000000, 32'hBF800000, 1'b0};
    vecs[5]  = '{32'h7F800000, 32'h3EC7AE14, 32'h00000000, 1'b1};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 1'b1};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1};
    vecs[8]  = '{32'h00400000, 32'h3F800000, 32'h3F800000, 1'b0};
    vecs[9]  = '{32'h00800001, 32'h80800000, 32'h00000000, 1'b0};
    vecs[10] = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{32'h3F800000, 32'h32800000, 32'h3F800000, 1'b0};

    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; a = '0; b = '0; last = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out",       out,                32'd0);
    chk("rst_ex",        {31'd0, ex},        32'd0);
    chk("rst_cnt",       {24'd0, cnt},       32'd0);
    rst_n = 1'b1;

    // Accept edge T; out_valid is seen after edge T+3.
    for (int i = 0; i < 12; i++) begin
      send(1'b0, vecs[i].va, vecs[i].vb, 1'b0);
      wait_out(n);
      chk($sformatf("v%0d_latency", i), n, 32'd3);
      chk($sformatf("v%0d_out", i), out, vecs[i].exp_out);
      chk($sformatf("v%0d_ex", i), {31'd0, ex}, {31'd0, vecs[i].exp_ex});
      chk($sformatf("v%0d_cnt", i), {24'd0, cnt}, 32'd1);
      tick();
      chk($sformatf("v%0d_ov_after", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_ir_after", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("v%0d_out_hold", i), out, vecs[i].exp_out);
    end

    // Accumulate 1+2+3+4; later beats drive mode=0 and b=Inf, both must be ignored.
    acc_vals[0] = 32'h3F800000; acc_vals[1] = 32'h40000000;
    acc_vals[2] = 32'h40400000; acc_vals[3] = 32'h40800000;
    for (int k = 0; k < 4; k++) begin
      send(k == 0, acc_vals[k], 32'h7F800000, k == 3);
      if (k < 3) begin
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("acc%0d_busy%0d_ir", k, j), {31'd0, in_ready}, 32'd0);
          chk($sformatf("acc%0d_busy%0d_ov", k, j), {31'd0, out_valid}, 32'd0);
          tick();
        end
        chk($sformatf("acc%0d_ir_back", k), {31'd0, in_ready}, 32'd1);
        chk($sformatf("acc%0d_no_ov", k), {31'd0, out_valid}, 32'd0);
      end
    end
    wait_out(n);
    chk("acc_latency", n, 32'd3);
    chk("acc_out", out, 32'h41200000);
    chk("acc_cnt", {24'd0, cnt}, 32'd4);
    chk("acc_ex",  {31'd0, ex}, 32'd0);
    tick();

    // Sticky exception: Inf mid-run zeroes the final result, later beats still counted.
    send(1'b1, 32'h3F800000, 32'h0, 1'b0);
    send(1'b1, 32'h7F800000, 32'h0, 1'b0);
    send(1'b1, 32'h40000000, 32'h0, 1'b1);
    wait_out(n);
    chk("sticky_latency", n, 32'd3);
    chk("sticky_out", out, 32'h00000000);
    chk("sticky_ex",  {31'd0, ex}, 32'd1);
    chk("sticky_cnt", {24'd0, cnt}, 32'd3);
    tick();

    // 260 beats of 1.0: sum 260.0, beat count saturates at 255.
    for (int k = 0; k < 260; k++) send(1'b1, 32'h3F800000, 32'h0, k == 259);
    wait_out(n);
    chk("sat_latency", n, 32'd3);
    chk("sat_out", out, 32'h43820000);
    chk("sat_cnt", {24'd0, cnt}, 32'd255);
    chk("sat_ex",  {31'd0, ex}, 32'd0);
    tick();

    // Backpressure: result held 3 cycles while a new beat waits at the input.
    out_ready = 1'b0;
    send(1'b0, 32'h3FC00000, 32'h40100000, 1'b0);
    wait_out(n);
    chk("bp_latency", n, 32'd3);
    chk("bp_out", out, 32'h40700000);
    mode = 1'b0; a = 32'h3F800000; b = 32'h3F800000; last = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("bp_hold%0d_ov", j), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_out", j), out, 32'h40700000);
      chk($sformatf("bp_hold%0d_ir", j), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_hold%0d_cnt", j), {24'd0, cnt}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_hs_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_hs_ir", {31'd0, in_ready}, 32'd1);
    chk("bp_hs_out_hold", out, 32'h40700000);
    tick();
    chk("bp_taken_ir", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_out(n);
    chk("bp2_latency", n, 32'd3);
    chk("bp2_out", out, 32'h40000000);
    chk("bp2_cnt", {24'd0, cnt}, 32'd1);
    tick();

    // Reset during ADD of the second accumulate beat, then a clean run.
    send(1'b1, 32'h3F800000, 32'h0, 1'b0);
    send(1'b1, 32'h40000000, 32'h0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ov",  {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_ex",  {31'd0, ex}, 32'd0);
    chk("mid_rst_cnt", {24'd0, cnt}, 32'd0);
    chk("mid_rst_ir",  {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    send(1'b1, 32'h40A00000, 32'h0, 1'b0);
    send(1'b1, 32'h3F800000, 32'h0, 1'b1);
    wait_out(n);
    chk("post_rst_latency", n, 32'd3);
    chk("post_rst_out", out, 32'h40C00000);
    chk("post_rst_cnt", {24'd0, cnt}, 32'd2);
    chk("post_rst_ex",  {31'd0, ex}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_acc_seq.md
# fp_acc_seq

Parametrised, multi-cycle floating-point adder/accumulator for the FFT datapath. It is the sequential successor of the combinational single-precision adder. It adds operand pairs (mode 0) or sums a stream of values into a running total (mode 1), using a valid/ready handshake on both sides. Format, round-toward-zero behaviour and exception-to-zero behaviour match the existing adder, so FFT butterflies and bin accumulators can use it directly.

## Interface
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa width (hidden bit implied); word width W = 1+EXP_W+MAN_W
- CNT_W, 8, width of the beat counter
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- mode  in  1  0 = out = a+b; 1 = accumulate a over a run (b ignored)
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- a  in  W  operand A / accumulate value
- b  in  W  operand B (mode 0 only)
- last  in  1  final beat of an accumulate run (ignored in mode 0)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  W  sum
- ex  out  1  exception: Inf/NaN input or overflow seen in this result
- cnt  out  CNT_W  beats summed into this result (saturates at all-ones)

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, OUT.
- IDLE: in_ready=1. A beat is accepted when in_valid & in_ready. On accept, the FSM goes to ALIGN.
- mode is latched on the first beat of a run. It is ignored on later beats until the run ends.
- Run end: mode 0 ends after every beat; mode 1 ends on the beat with last=1.
- On the first beat of a run, the accumulator, sticky ex and cnt clear. Mode 1 operand pair = (acc, a), with acc = +0 on the first beat.
- ALIGN:
  - Inputs with exponent 0 flush to zero.
  - Exponent all-ones (Inf/NaN) sets sticky ex.
  - Order operands by magnitude.
  - Shift the smaller mantissa (hidden bit included) right by the exponent difference. A difference > MAN_W+1 gives zero. Shifted-out bits are discarded.
- ADD: add mantissas if the signs are equal, otherwise subtract the smaller from the larger. Result sign = sign of the larger-magnitude operand.
- NORM:
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise shift left by the leading-zero count and decrement the exponent.
  - Exact zero gives +0.
  - Exponent underflow (≤0) flushes to +0, no ex.
  - Exponent ≥ all-ones sets ex.
  - Rounding is truncation (toward zero).
- After NORM:
  - Run continues (mode 1, last=0): store the result to acc, cnt += 1, go to IDLE.
  - Run ends: go to OUT.
- OUT:
  - out_valid=1. out = result, or all-zeros if ex=1.
  - On out_valid & out_ready, go to IDLE.
- Sticky ex in mode 1: any exceptional beat forces final out=0 and ex=1. Later beats are still accepted and counted.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, acc=0, in_ready=1, out_valid=0, out=0, ex=0, cnt=0. Reset takes effect mid-run or mid-OUT as well; a pending result is dropped.
- Latency: beat accepted at edge T → ALIGN, ADD, NORM in cycles T+1..T+3 → out_valid=1 in the cycle after edge T+3 (4 cycles).
- Mode 1 intermediate beat: in_ready returns high 4 cycles after accept. Maximum rate is 1 beat per 4 cycles.
- in_ready=0 in ALIGN, ADD, NORM and OUT. in_valid is ignored in those states; a held beat is taken on return to IDLE.
- Backpressure: out, ex and cnt stay stable while out_valid=1 & out_ready=0.
- out_valid deasserts on the edge where the handshake completes. in_ready rises in the same cycle (IDLE).
- out, ex and cnt hold their last values after the handshake until the next result.
- Mode 0 result: cnt=1.

## Test plan
- Mode 0 pairs:
  - 0x3FC00000 + 0x40100000 → 0x40700000 (3.75), ex=0, out_valid 4 cycles after accept.
  - 0x4B7FFFFF + 0x3F800000 → 0x4B800000.
  - 0x4B7FFFFF + 0x40000000 → 0x4B800000 (truncation).
- Cancellation/sign: 0xBF800000 + 0x3F800000 → 0x00000000. 0x3F800000 + 0xC0000000 → 0xBF800000.
- Exception: 0x7F800000 + 0x3EC7AE14 → out=0x00000000, ex=1. Overflow 0x7F7FFFFF + 0x7F7FFFFF → out=0, ex=1.
- Accumulate: mode 1, a = 1.0, 2.0, 3.0, 4.0 (last on 4th) → single result 0x41200000, cnt=4. in_ready is low for 4 cycles after each accept. No out_valid before the last beat.
- Backpressure: hold out_ready=0 for 3 cycles in OUT → out stable, in_ready=0, a new in_valid is not taken until the cycle after the handshake.
- Reset mid-run: assert rst_n=0 during ADD of the 2nd accumulate beat → next cycle out_valid=0, out=0, ex=0, cnt=0, in_ready=1. A fresh run of 5.0 then 1.0 (last) → 0x40C00000.
